// File: rtl/tlc_phase_sched.sv
// Traffic-light phase scheduler for a main/side intersection with a pedestrian phase and an
// emergency override. One shared countdown timer paces every phase.
module tlc_phase_sched #(
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned T_MAIN   = 16,
    parameter int unsigned T_SIDE   = 8,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_WALK   = 6,
    parameter int unsigned T_ALLRED = 1
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             CAR_SIDE,
    input  logic             PED_REQ,
    input  logic             EMERG,
    output logic [1:0]       MAIN_LT,
    output logic [1:0]       SIDE_LT,
    output logic             WALK,
    output logic             PED_PEND,
    output logic [2:0]       PHASE,
    output logic [CNT_W-1:0] TIMER
);

    typedef enum logic [2:0] {
        StMg  = 3'd0,
        StMy  = 3'd1,
        StAr1 = 3'd2,
        StSg  = 3'd3,
        StSy  = 3'd4,
        StAr2 = 3'd5,
        StPw  = 3'd6,
        StEm  = 3'd7
    } state_e;

    localparam logic [1:0] LtRed = 2'b00;
    localparam logic [1:0] LtYel = 2'b01;
    localparam logic [1:0] LtGrn = 2'b10;

    localparam logic [CNT_W-1:0] LdMain   = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] LdSide   = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] LdYel    = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] LdWalk   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LdAllred = CNT_W'(T_ALLRED - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_q, ped_d;
    logic             done;
    logic [CNT_W-1:0] load_val;

    always_comb begin
        done    = (timer_q == '0);
        state_d = state_q;
        if (EMERG && (state_q != StEm)) begin
            state_d = StEm;
        end else begin
            case (state_q)
                StMg:    if (done && (CAR_SIDE || ped_q)) state_d = StMy;
                StMy:    if (done) state_d = StAr1;
                StAr1:   if (done) state_d = ped_q ? StPw : StSg;
                StPw:    if (done) state_d = CAR_SIDE ? StSg : StAr2;
                StSg:    if (done) state_d = StSy;
                StSy:    if (done) state_d = StAr2;
                StAr2:   if (done) state_d = StMg;
                StEm:    if (!EMERG) state_d = StAr2;
                default: state_d = StAr2;
            endcase
        end
    end

    always_comb begin
        case (state_d)
            StMg:          load_val = LdMain;
            StMy, StSy:    load_val = LdYel;
            StSg:          load_val = LdSide;
            StPw:          load_val = LdWalk;
            default:       load_val = LdAllred;
        endcase

        if (state_d != state_q) begin
            timer_d = load_val;
        end else if (done) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q - 1'b1;
        end

        // Entering the walk phase serves the request, even one arriving on the same edge.
        ped_d = ped_q;
        if ((state_d == StPw) && (state_q != StPw)) begin
            ped_d = 1'b0;
        end else if (PED_REQ && (state_q != StPw)) begin
            ped_d = 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= StAr2;
            timer_q <= LdAllred;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        MAIN_LT = LtRed;
        SIDE_LT = LtRed;
        WALK    = 1'b0;
        case (state_q)
            StMg:    MAIN_LT = LtGrn;
            StMy:    MAIN_LT = LtYel;
            StSg:    SIDE_LT = LtGrn;
            StSy:    SIDE_LT = LtYel;
            StPw:    WALK    = 1'b1;
            default: ;
        endcase
    end

    assign PHASE    = state_q;
    assign TIMER    = timer_q;
    assign PED_PEND = ped_q;

endmodule
